// File: rtl/ifu_fetch.sv
// ifu_fetch: multi-cycle instruction fetch unit.
// Owns the fetch PC and keeps at most one instruction-memory read in flight.
// Each returned instruction is handed to decode together with its PC.
// A redirect from execute discards any stale in-flight or held instruction.
module ifu_fetch #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        jump_en,
  input  logic [63:0] jump_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [63:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [63:0] inst_pc
);

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  localparam logic [63:0] RESET_PC_ALIGNED = {RESET_PC[63:2], 2'b00};

  state_e      state_q, state_d;
  logic [63:0] fetch_pc_q, fetch_pc_d;
  logic [63:0] req_pc_q, req_pc_d;
  logic        kill_q, kill_d;
  logic [31:0] inst_q, inst_d;
  logic [63:0] inst_pc_q, inst_pc_d;

  logic [63:0] jump_target;
  logic [1:0]  jump_pc_unused;

  // The low two bits of a redirect target are dropped so every fetch address stays word aligned.
  assign jump_target    = {jump_pc[63:2], 2'b00};
  assign jump_pc_unused = jump_pc[1:0];

  assign imem_req_addr = fetch_pc_q;
  assign inst          = inst_q;
  assign inst_pc       = inst_pc_q;

  // Next-state and handshake outputs: request in REQ, collect the response in WAIT, present it in HOLD.
  always_comb begin
    state_d        = state_q;
    fetch_pc_d     = fetch_pc_q;
    req_pc_d       = req_pc_q;
    kill_d         = kill_q;
    inst_d         = inst_q;
    inst_pc_d      = inst_pc_q;
    imem_req_valid = 1'b0;
    inst_valid     = 1'b0;

    case (state_q)
      ST_REQ: begin
        imem_req_valid = 1'b1;
        if (imem_req_ready) begin
          req_pc_d = fetch_pc_q;
          state_d  = ST_WAIT;
          if (jump_en) begin
            // The request already went out with the old address; its response must be dropped.
            kill_d     = 1'b1;
            fetch_pc_d = jump_target;
          end
        end else if (jump_en) begin
          fetch_pc_d = jump_target;
        end
      end

      ST_WAIT: begin
        if (imem_rsp_valid) begin
          if (kill_q || jump_en) begin
            kill_d  = 1'b0;
            state_d = ST_REQ;
            if (jump_en) begin
              fetch_pc_d = jump_target;
            end
          end else begin
            inst_d     = imem_rsp_data;
            inst_pc_d  = req_pc_q;
            fetch_pc_d = req_pc_q + 64'd4;
            state_d    = ST_HOLD;
          end
        end else if (jump_en) begin
          kill_d     = 1'b1;
          fetch_pc_d = jump_target;
        end
      end

      ST_HOLD: begin
        inst_valid = 1'b1;
        if (jump_en) begin
          fetch_pc_d = jump_target;
          state_d    = ST_REQ;
        end else if (inst_ready) begin
          state_d = ST_REQ;
        end
      end

      default: begin
        state_d = ST_REQ;
      end
    endcase
  end

  // State register with synchronous reset back to a fresh fetch at the reset PC.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_REQ;
      fetch_pc_q <= RESET_PC_ALIGNED;
      req_pc_q   <= 64'd0;
      kill_q     <= 1'b0;
      inst_q     <= 32'd0;
      inst_pc_q  <= 64'd0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      kill_q     <= kill_d;
      inst_q     <= inst_d;
      inst_pc_q  <= inst_pc_d;
    end
  end

endmodule
